// File: rtl/bus6502_pkg.sv
// Shared types and constants for the 6502 test-system bus initiator.
package bus6502_pkg;

  // Bus-cycle sequencer states; VFY is only entered when WRITE_VERIFY_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    VFY  = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Width of the half-period counter; holds HALF-1 for HALF up to 255.
  localparam int HALF_W = 8;

endpackage

// File: rtl/bus6502_phase_ctr.sv
// Phase generator: loadable half-period down-counter plus the phi register.
// start reloads the counter and raises phi; end_ph1 drops phi and reloads
// for the low half; end_ph2 marks the last eclk of the bus cycle.
module bus6502_phase_ctr
  import bus6502_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic eclk,
  input  logic ereset_n,
  input  logic start,
  input  logic in_ph1,
  input  logic in_ph2,
  output logic phi,
  output logic cnt_zero,
  output logic end_ph1,
  output logic end_ph2
);

  localparam logic [HALF_W-1:0] RELOAD = HALF_W'(HALF - 1);

  logic [HALF_W-1:0] cnt;

  assign cnt_zero = (cnt == '0);
  assign end_ph1  = in_ph1 && cnt_zero;
  assign end_ph2  = in_ph2 && cnt_zero;

  // Counter and phi: start wins over the phase-1 terminal count so a
  // back-to-back accept raises phi on the same edge the previous cycle ends.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      cnt <= '0;
      phi <= 1'b0;
    end else if (start) begin
      cnt <= RELOAD;
      phi <= 1'b1;
    end else if (end_ph1) begin
      cnt <= RELOAD;
      phi <= 1'b0;
    end else if ((in_ph1 || in_ph2) && !cnt_zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bus6502_master.sv
// Bus initiator for the 6502 test-system memory bus: turns valid/ready
// requests into phi-clocked bus cycles and returns a one-cycle response.
// Optional feature macro: WRITE_VERIFY_EN (read back every write and flag
// mismatches on rsp_err).
module bus6502_master
  import bus6502_pkg::*;
#(
  parameter int HALF   = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              eclk,
  input  logic              ereset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              phi,
  output logic [ADDR_W-1:0] a,
  output logic              rw,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  if (HALF < 2 || HALF > 255) begin : g_bad_half
    $error("bus6502_master: HALF must be within 2..255");
  end

  state_t state, state_n;
  logic   alive;
  logic   we_q;
  logic   start, accept, fin, to_vfy;
  logic   in_ph1, in_ph2;
  logic   cnt_zero, end_ph1, end_ph2;
  logic   vfy_pending;
  logic   mismatch;

`ifdef WRITE_VERIFY_EN
  // A write owes a read-back from accept until the VFY cycle ends, so the
  // request port stays closed for the whole 4*HALF write.
  assign vfy_pending = we_q || (state == VFY);
  assign in_ph1      = (state == PH1) || ((state == VFY) && phi);
  assign in_ph2      = (state == PH2) || ((state == VFY) && !phi);
  assign mismatch    = (state == VFY) && (bus_rdata != bus_wdata);
`else
  assign vfy_pending = 1'b0;
  assign in_ph1      = (state == PH1);
  assign in_ph2      = (state == PH2);
  assign mismatch    = 1'b0;
`endif

  bus6502_phase_ctr #(
    .HALF(HALF)
  ) u_phase (
    .eclk    (eclk),
    .ereset_n(ereset_n),
    .start   (start),
    .in_ph1  (in_ph1),
    .in_ph2  (in_ph2),
    .phi     (phi),
    .cnt_zero(cnt_zero),
    .end_ph1 (end_ph1),
    .end_ph2 (end_ph2)
  );

  // Next-state and cycle-control decode.
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    fin       = 1'b0;
    to_vfy    = 1'b0;
    req_ready = alive && ((state == IDLE) ||
                          ((state == PH2) && cnt_zero && !vfy_pending));
    accept    = req_valid && req_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = PH1;
          start   = 1'b1;
        end
      end
      PH1: begin
        if (end_ph1) state_n = PH2;
      end
      PH2: begin
        if (end_ph2) begin
`ifdef WRITE_VERIFY_EN
          if (we_q) begin
            state_n = VFY;
            start   = 1'b1;
            to_vfy  = 1'b1;
          end else
`endif
          begin
            fin = 1'b1;
            if (accept) begin
              state_n = PH1;
              start   = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
`ifdef WRITE_VERIFY_EN
      VFY: begin
        if (end_ph2) begin
          fin     = 1'b1;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // State, bus drive and response registers; a/rw/bus_wdata only change on
  // accept or at cycle end, so they stay stable across the write strobe.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      state     <= IDLE;
      alive     <= 1'b0;
      we_q      <= 1'b0;
      a         <= '0;
      rw        <= 1'b1;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      alive     <= 1'b1;
      rsp_valid <= fin;
      if (fin) begin
        rsp_we    <= we_q;
        rsp_rdata <= (we_q && (state != VFY)) ? '0 : bus_rdata;
        rsp_err   <= mismatch;
      end
      if (accept) begin
        a         <= req_addr;
        rw        <= !req_we;
        bus_wdata <= req_we ? req_wdata : '0;
        we_q      <= req_we;
      end else if (fin || to_vfy) begin
        rw <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus6502_master.sv
// Bench for bus6502_master (HALF=2) with an attached RAM responder model.
module tb_bus6502_master;

  localparam int HALF = 2;

`ifdef WRITE_VERIFY_EN
  localparam bit VFY_ON = 1'b1;
  localparam int WLAT   = 4 * HALF;
  localparam int GAP    = 4 * HALF + 1;
`else
  localparam bit VFY_ON = 1'b0;
  localparam int WLAT   = 2 * HALF;
  localparam int GAP    = 2 * HALF;
`endif
  localparam int RLAT = 2 * HALF;

  logic        eclk = 1'b0;
  logic        ereset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_we = 1'b0;
  logic        rsp_valid, rsp_we, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        phi, rw;
  logic [15:0] a;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int wr_cnt = 0;

  logic [7:0] mem [0:65535] = '{default: 8'h00};
  logic [7:0] stuck_mask = 8'h00;
  logic       phi_q = 1'b0;

  typedef struct {
    logic       we;
    logic [7:0] rdata;
    logic       err;
    int         due;
  } exp_t;

  exp_t sbq[$];
  exp_t me;

  bus6502_master #(.HALF(HALF), .ADDR_W(16), .DATA_W(8)) dut (
    .eclk     (eclk),
    .ereset_n (ereset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_we   (req_we),
    .rsp_valid(rsp_valid),
    .rsp_we   (rsp_we),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .phi      (phi),
    .a        (a),
    .rw       (rw),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  always #5 eclk = ~eclk;

  always @(posedge eclk) cyc <= cyc + 1;

  // Responder: writes on the first eclk edge after phi falls, dout registered one eclk behind a.
  always @(posedge eclk) begin
    if (phi_q && !phi && !rw) begin
      mem[a] <= bus_wdata & ~stuck_mask;
      wr_cnt <= wr_cnt + 1;
    end
    phi_q     <= phi;
    bus_rdata <= mem[a];
  end

  // Scoreboard: pop and compare each response pulse.
  always @(negedge eclk) begin
    if (ereset_n && rsp_valid) begin
      rsp_cnt++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got we=%0b rdata=%02h want no response", rsp_we, rsp_rdata);
      end else begin
        me = sbq.pop_front();
        if ({rsp_we, rsp_rdata, rsp_err} !== {me.we, me.rdata, me.err}) begin
          bad++;
          $display("FAIL rsp_data got we=%0b rdata=%02h err=%0b want we=%0b rdata=%02h err=%0b",
                   rsp_we, rsp_rdata, rsp_err, me.we, me.rdata, me.err);
        end
        total++;
        if (cyc != me.due) begin
          bad++;
          $display("FAIL rsp_latency got cycle=%0d want %0d", cyc, me.due);
        end
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, push its expected response.
  task automatic issue(input logic [15:0] ad, input logic [7:0] wd, input logic we,
                       input logic [7:0] er, input logic ee, input int lat, output int t0);
    int n;
    exp_t e;
    req_addr  = ad;
    req_wdata = wd;
    req_we    = we;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge eclk);
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL accept_timeout got ready=%0b want 1", req_ready);
      t0 = -1;
      return;
    end
    @(posedge eclk);
    @(negedge eclk);
    t0 = cyc;
    e.we = we; e.rdata = er; e.err = ee; e.due = t0 + lat;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    #2 ereset_n = 1'b0;
    #1;
    total++;
    if ({phi, rw, a, bus_wdata, rsp_valid, rsp_we, rsp_rdata, rsp_err, req_ready} !==
        {1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got phi=%0b rw=%0b a=%04h wd=%02h rv=%0b ready=%0b want 0 1 0000 00 0 0",
               phi, rw, a, bus_wdata, rsp_valid, req_ready);
    end
    repeat (3) @(negedge eclk);
    ereset_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_alive got %0b want 0", req_ready);
    end
    @(negedge eclk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_alive got %0b want 1", req_ready);
    end
  endtask

  task automatic test_write();
    int t0;
    logic phi_e, rw_e;
    issue(16'h1234, 8'hA5, 1'b1, VFY_ON ? 8'hA5 : 8'h00, 1'b0, WLAT, t0);
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      phi_e = VFY_ON ? (k < 2 || k == 4 || k == 5) : (k < 2);
      rw_e  = (k >= 4);
      total++;
      if ({phi, rw, a} !== {phi_e, rw_e, 16'h1234}) begin
        bad++;
        $display("FAIL write_phase k=%0d got phi=%0b rw=%0b a=%04h want %0b %0b 1234",
                 k, phi, rw, a, phi_e, rw_e);
      end
      total++;
      if (rsp_valid !== (k == WLAT)) begin
        bad++;
        $display("FAIL write_rsp_pulse k=%0d got %0b want %0b", k, rsp_valid, (k == WLAT));
      end
      @(negedge eclk);
    end
    total++;
    if (mem[16'h1234] !== 8'hA5) begin
      bad++;
      $display("FAIL write_mem got %02h want A5", mem[16'h1234]);
    end
  endtask

  task automatic test_read();
    int t0;
    issue(16'h1234, 8'h00, 1'b0, 8'hA5, 1'b0, RLAT, t0);
    req_valid = 1'b0;
    for (int k = 0; k < RLAT; k++) begin
      total++;
      if (rw !== 1'b1) begin
        bad++;
        $display("FAIL read_rw k=%0d got %0b want 1", k, rw);
      end
      @(negedge eclk);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      bad++;
      $display("FAIL read_data got valid=%0b rdata=%02h want 1 A5", rsp_valid, rsp_rdata);
    end
    @(negedge eclk);
  endtask

  task automatic test_back_to_back();
    int t0a, t0b, t0c, base;
    base = rsp_cnt;
    issue(16'h0000, 8'h11, 1'b1, VFY_ON ? 8'h11 : 8'h00, 1'b0, WLAT, t0a);
    issue(16'h0001, 8'h22, 1'b1, VFY_ON ? 8'h22 : 8'h00, 1'b0, WLAT, t0b);
    issue(16'hFFFF, 8'h33, 1'b1, VFY_ON ? 8'h33 : 8'h00, 1'b0, WLAT, t0c);
    req_valid = 1'b0;
    total++;
    if (t0b - t0a != GAP || t0c - t0b != GAP) begin
      bad++;
      $display("FAIL b2b_spacing got %0d,%0d want %0d", t0b - t0a, t0c - t0b, GAP);
    end
    repeat (WLAT + 2) @(negedge eclk);
    total++;
    if (rsp_cnt - base != 3) begin
      bad++;
      $display("FAIL b2b_rsp_count got %0d want 3", rsp_cnt - base);
    end
    total++;
    if ({mem[16'h0000], mem[16'h0001], mem[16'hFFFF]} !== 24'h112233) begin
      bad++;
      $display("FAIL b2b_mem got %02h %02h %02h want 11 22 33",
               mem[16'h0000], mem[16'h0001], mem[16'hFFFF]);
    end
  endtask

  task automatic test_reset_mid();
    int t0, rbase, wbase;
    logic [7:0] snap;
    snap  = mem[16'h0100];
    rbase = rsp_cnt;
    wbase = wr_cnt;
    issue(16'h0100, 8'h77, 1'b1, 8'h00, 1'b0, WLAT, t0);
    req_valid = 1'b0;
    @(posedge eclk);
    #2 ereset_n = 1'b0;
    sbq.delete();
    #1;
    total++;
    if ({phi, rw, a, bus_wdata, rsp_valid, req_ready} !== {1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_values got phi=%0b rw=%0b a=%04h wd=%02h rv=%0b ready=%0b want 0 1 0000 00 0 0",
               phi, rw, a, bus_wdata, rsp_valid, req_ready);
    end
    repeat (3) @(negedge eclk);
    ereset_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_ready_early got %0b want 0", req_ready);
    end
    @(negedge eclk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_ready_late got %0b want 1", req_ready);
    end
    repeat (8) @(negedge eclk);
    total++;
    if (mem[16'h0100] !== snap || wr_cnt != wbase || rsp_cnt != rbase) begin
      bad++;
      $display("FAIL midreset_dropped got mem=%02h writes=%0d rsps=%0d want %02h %0d %0d",
               mem[16'h0100], wr_cnt - wbase, rsp_cnt - rbase, snap, 0, 0);
    end
  endtask

  task automatic test_idle();
    int wbase;
    wbase = wr_cnt;
    for (int k = 0; k < 20; k++) begin
      @(negedge eclk);
      total++;
      if ({phi, rw, req_ready, rsp_valid} !== 4'b0110) begin
        bad++;
        $display("FAIL idle k=%0d got phi=%0b rw=%0b ready=%0b rv=%0b want 0 1 1 0",
                 k, phi, rw, req_ready, rsp_valid);
      end
    end
    total++;
    if (wr_cnt != wbase) begin
      bad++;
      $display("FAIL idle_writes got %0d want 0", wr_cnt - wbase);
    end
  endtask

`ifdef WRITE_VERIFY_EN
  task automatic test_verify();
    int t0;
    stuck_mask = 8'h02;
    issue(16'h0200, 8'h5A, 1'b1, 8'h58, 1'b1, WLAT, t0);
    req_valid = 1'b0;
    repeat (WLAT + 2) @(negedge eclk);
    issue(16'h0201, 8'h55, 1'b1, 8'h55, 1'b0, WLAT, t0);
    req_valid = 1'b0;
    repeat (WLAT + 2) @(negedge eclk);
    total++;
    if (mem[16'h0200] !== 8'h58) begin
      bad++;
      $display("FAIL verify_mem got %02h want 58", mem[16'h0200]);
    end
    stuck_mask = 8'h00;
  endtask
`endif

  initial begin
    int n;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_idle();
`ifdef WRITE_VERIFY_EN
    test_verify();
`endif
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge eclk);
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus6502_master.md
Name: bus6502_master

Overview:
- Bus initiator for the 6502 test-system memory bus.
- Accepts read/write requests on a valid/ready interface, generates the phase clock, and drives the address, rw and write data.
- Samples the read data from the RAM/peripheral responder.
- Used by loaders, DMA and testbenches to drive the same bus a 6502 core would, without a CPU present.

Parameters:
HALF, 2, eclk cycles per phi half-period; legal range 2..255; elaboration error outside it.
ADDR_W, 16, bus address width.
DATA_W, 8, bus data width.

Ports:
eclk  in  1  system clock; all logic on its rising edge.
ereset_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted on an edge where valid && ready.
req_addr  in  ADDR_W  request address.
req_wdata  in  DATA_W  write data.
req_we  in  1  1 = write, 0 = read.
rsp_valid  out  1  one-cycle completion pulse; no backpressure.
rsp_we  out  1  echoes the request type.
rsp_rdata  out  DATA_W  read data; 0 for writes.
rsp_err  out  1  write-verify mismatch; see Optional Feature.
phi  out  1  bus phase clock to the responder's clk input.
a  out  ADDR_W  bus address.
rw  out  1  1 = read, 0 = write.
bus_wdata  out  DATA_W  to the responder's din.
bus_rdata  in  DATA_W  from the responder's dout, which is registered one eclk behind a.

Behaviour:
- Reset (async): state IDLE, phi=0, a=0, rw=1, bus_wdata=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_err=0, cnt=0, alive=0.
- alive sets on the first eclk after reset release.
- req_ready = alive && (state==IDLE || (state==PH2 && cnt==0 && !vfy_pending)).
- States: IDLE, PH1, PH2, plus VFY (only with the macro).
- Accept (valid && ready):
  - a <= req_addr; rw <= !req_we; bus_wdata <= req_we ? req_wdata : 0.
  - Latch the type; phi <= 1; cnt <= HALF-1; go to PH1.
- PH1: cnt decrements each eclk. At cnt==0: phi <= 0, cnt <= HALF-1, go to PH2.
- PH2: cnt decrements. At cnt==0 the cycle ends:
  - Read: rsp_valid <= 1, rsp_rdata <= bus_rdata.
  - Write: rsp_valid <= 1, rsp_rdata <= 0.
  - Then: next accept if req_valid (back-to-back, phi rises on the same edge); else IDLE with rw <= 1, a held, bus_wdata held.
- a, rw and bus_wdata are held constant from accept through the last PH2 edge.
  - This covers the responder's write strobe, which is the first eclk edge after phi falls.
  - Never drive rw=0 while phi toggles outside a write cycle.
- Latency: accept at edge T0; phi high T0..T0+HALF; phi low T0+HALF..T0+2*HALF; rsp_valid high in the cycle after edge T0+2*HALF.
- Throughput: one bus cycle per 2*HALF eclk.
- rsp_valid is a 1-cycle pulse; it is 0 on all other cycles.
- In IDLE, phi stays 0, so the responder sees no falling edge and no write occurs.
- Reset asserted mid-cycle: immediate return to reset values; the in-flight request is dropped with no response. A write is only guaranteed if reset deasserts after the phi-fall edge.
- A request presented while not ready is held by the requester; the master never samples it.
- Address and counter arithmetic are unsigned; no wrap logic is needed (a is taken verbatim).

Optional Feature:
- Macro WRITE_VERIFY_EN.
- Defined:
  - After a write's PH2 end, vfy_pending=1 and no response is issued yet.
  - The master runs a read bus cycle to the same a (state VFY, same PH1/PH2 timing, rw=1).
  - At its end: a single rsp_valid with rsp_we=1; rsp_rdata = the read-back value; rsp_err = (read-back != written data).
  - req_ready is low throughout; write latency = 4*HALF.
- Undefined: rsp_err tied 0, no VFY state.

Decomposition:
- Package bus6502_pkg: state enum (IDLE, PH1, PH2, VFY), ADDR_W/DATA_W defaults, HALF width constant.
- One sub-module: bus6502_phase_ctr. It holds the loadable down-counter and phi register, and outputs the end_ph1/end_ph2 strobes. It is instantiated once.

Test Plan (HALF=2, responder model attached):
1. Write 0x1234<-0xA5 from IDLE, accepted at T0 -> phi=1 at T0..T0+2, 0 at T0+2..T0+4; rw=0 and a=0x1234 held through T0+4; mem[0x1234]==0xA5; rsp_valid high after edge T0+4, rsp_we=1.
2. Read 0x1234 after test 1 -> rsp_rdata=0xA5 after edge T0+4; rw=1 throughout.
3. Back-to-back writes to 0x0000, 0x0001, 0xFFFF with req_valid held -> three cycles of 4 eclk each, no idle gap; phi period 4; all three bytes stored; exactly 3 rsp pulses.
4. Reset pulled low at T0+1 of a write to 0x0100 -> outputs at reset values immediately; mem[0x0100] unchanged; no rsp; req_ready=0 until the first eclk after release.
5. Idle 20 cycles after reset -> phi=0, rw=1, no responder writes, req_ready=1.
6. WRITE_VERIFY_EN, responder stuck-at-0 bit forces 0x5A->0x58 -> single rsp after 8 eclk with rsp_rdata=0x58, rsp_err=1; a matching write gives rsp_err=0.
